// File: rtl/free_list_ctrl_pkg.sv
// Shared sizing defaults and width helpers for the physical-register free list.
package free_list_ctrl_pkg;

   localparam int unsigned DEF_N         = 3;
   localparam int unsigned DEF_PHYS_REGS = 64;
   localparam int unsigned DEF_ARCH_REGS = 32;

   // Index width needed to name one of n entries.
   function automatic int unsigned idx_bits(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width needed to hold a count in the range 0..n.
   function automatic int unsigned scalar_bits(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/free_list_ctrl_if.sv
// Dispatch / recovery / retire bundle between the rename stage and the free list.
interface free_list_ctrl_if
   import free_list_ctrl_pkg::*;
#(
   parameter int unsigned N         = DEF_N,
   parameter int unsigned PHYS_REGS = DEF_PHYS_REGS
);

   localparam int unsigned PHYS_REG_IDX    = idx_bits(PHYS_REGS);
   localparam int unsigned NUM_SCALAR_BITS = scalar_bits(N);

   logic [PHYS_REGS-1:0]                updated_free_list;
   logic [NUM_SCALAR_BITS-1:0]          num_dispatched;
   logic                                restore_valid;
   logic [PHYS_REGS-1:0]                free_list_restore;
   logic [N-1:0]                        retire_valid;
   logic [N-1:0][PHYS_REG_IDX-1:0]      retire_reg;

   logic [N-1:0][PHYS_REG_IDX-1:0]      regs_to_use;
   logic [PHYS_REGS-1:0]                free_list_copy;
   logic [NUM_SCALAR_BITS-1:0]          num_regs_available;
   logic [PHYS_REGS-1:0]                retire_free_mask;
   logic                                double_free_err;
   logic                                alloc_overflow_err;

   // Rename / retire logic side.
   modport master (
      output updated_free_list, num_dispatched, restore_valid,
             free_list_restore, retire_valid, retire_reg,
      input  regs_to_use, free_list_copy, num_regs_available,
             retire_free_mask, double_free_err, alloc_overflow_err
   );

   // Free list side.
   modport slave (
      input  updated_free_list, num_dispatched, restore_valid,
             free_list_restore, retire_valid, retire_reg,
      output regs_to_use, free_list_copy, num_regs_available,
             retire_free_mask, double_free_err, alloc_overflow_err
   );

endinterface

// File: rtl/psel_gen.sv
// Priority selector: REQS one-hot grants for the lowest set request bits, ascending.
module psel_gen #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned REQS  = 3
) (
   input  logic [WIDTH-1:0]            req,
   output logic [REQS-1:0][WIDTH-1:0]  gnt_bus
);

   logic [WIDTH-1:0] remain;

   // Peel off the lowest remaining request once per grant slot.
   always_comb begin
      remain  = req;
      gnt_bus = '0;
      for (int unsigned k = 0; k < REQS; k++) begin
         gnt_bus[k] = remain & (~remain + WIDTH'(1));
         remain     = remain & ~gnt_bus[k];
      end
   end

endmodule

// File: rtl/free_list_ctrl.sv
// Physical-register free list: lowest-N allocation, retire frees, checkpoint restore.
module free_list_ctrl
   import free_list_ctrl_pkg::*;
#(
   parameter int unsigned N         = DEF_N,
   parameter int unsigned PHYS_REGS = DEF_PHYS_REGS,
   parameter int unsigned ARCH_REGS = DEF_ARCH_REGS
) (
   input  logic             clock,
   input  logic             reset,
   free_list_ctrl_if.slave  bus
);

   localparam int unsigned PHYS_REG_IDX    = idx_bits(PHYS_REGS);
   localparam int unsigned NUM_SCALAR_BITS = scalar_bits(N);
   localparam int unsigned POP_W           = scalar_bits(PHYS_REGS);

   localparam logic [PHYS_REGS-1:0] ALL_ONES  = '1;
   // Architectural registers start identity-mapped (busy); reg 0 is never free.
   localparam logic [PHYS_REGS-1:0] RESET_VEC =
      (ALL_ONES << ARCH_REGS) & ~PHYS_REGS'(1);
   localparam logic [POP_W-1:0]     RESET_CNT = POP_W'(PHYS_REGS - ARCH_REGS);

   logic [PHYS_REGS-1:0]            free_q;
   logic [PHYS_REGS-1:0]            free_d;
   logic [POP_W-1:0]                cnt_q;
   logic [POP_W-1:0]                cnt_d;
   logic                            dbl_q;
   logic                            ovf_q;
   logic                            dbl_hit;
   logic                            ovf_hit;
   logic [PHYS_REGS-1:0]            ret_mask;
   logic [PHYS_REGS-1:0]            base_vec;
   logic [NUM_SCALAR_BITS-1:0]      avail;
   logic [N-1:0][PHYS_REGS-1:0]     gnt;
   logic [N-1:0][PHYS_REG_IDX-1:0]  sel_idx;

   // One-hot OR of this cycle's valid retire frees.
   always_comb begin
      ret_mask = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (bus.retire_valid[k]) begin
            ret_mask[bus.retire_reg[k]] = 1'b1;
         end
      end
   end

   // Available count saturates at the dispatch width; comes straight off the count register.
   always_comb begin
      avail = NUM_SCALAR_BITS'(N);
      if (cnt_q < POP_W'(N)) begin
         avail = NUM_SCALAR_BITS'(cnt_q);
      end
   end

   psel_gen #(
      .WIDTH (PHYS_REGS),
      .REQS  (N)
   ) u_psel (
      .req     (free_q),
      .gnt_bus (gnt)
   );

   // Encode one-hot grants to register indices; an empty grant encodes as 0.
   always_comb begin
      sel_idx = '0;
      for (int unsigned k = 0; k < N; k++) begin
         for (int unsigned i = 0; i < PHYS_REGS; i++) begin
            if (gnt[k][i]) begin
               sel_idx[k] = sel_idx[k] | PHYS_REG_IDX'(i);
            end
         end
      end
   end

   // Error detection: freeing a free reg, duplicate frees, dispatching beyond availability.
   always_comb begin
      dbl_hit = 1'b0;
      for (int unsigned k = 0; k < N; k++) begin
         if (bus.retire_valid[k] && free_q[bus.retire_reg[k]]) begin
            dbl_hit = 1'b1;
         end
         for (int unsigned j = k + 1; j < N; j++) begin
            if (bus.retire_valid[k] && bus.retire_valid[j] &&
                (bus.retire_reg[k] == bus.retire_reg[j])) begin
               dbl_hit = 1'b1;
            end
         end
      end
      ovf_hit = !bus.restore_valid && (bus.num_dispatched > avail);
   end

   // Next vector: restore overrides dispatch, retire frees always land, reg 0 stays busy.
   always_comb begin
      base_vec = bus.restore_valid ? bus.free_list_restore : bus.updated_free_list;
      free_d   = (base_vec | ret_mask) & ~PHYS_REGS'(1);
   end

   // Population count of the next vector, registered alongside it.
   always_comb begin
      cnt_d = '0;
      for (int unsigned i = 0; i < PHYS_REGS; i++) begin
         cnt_d = cnt_d + POP_W'(free_d[i]);
      end
   end

   // State update; error bits are sticky until reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         free_q <= RESET_VEC;
         cnt_q  <= RESET_CNT;
         dbl_q  <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         free_q <= free_d;
         cnt_q  <= cnt_d;
         dbl_q  <= dbl_q | dbl_hit;
         ovf_q  <= ovf_q | ovf_hit;
      end
   end

   assign bus.regs_to_use        = sel_idx;
   assign bus.free_list_copy     = free_q;
   assign bus.num_regs_available = avail;
   assign bus.retire_free_mask   = ret_mask;
   assign bus.double_free_err    = dbl_q;
   assign bus.alloc_overflow_err = ovf_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl with hand-computed expected vectors.
module tb_free_list_ctrl;

   logic clock;
   logic reset;
   int   n_tests;
   int   n_fail;
   logic [63:0] exp_fl;

   free_list_ctrl_if #(.N(3), .PHYS_REGS(64)) bus ();

   free_list_ctrl #(
      .N         (3),
      .PHYS_REGS (64),
      .ARCH_REGS (32)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag, input int r0, input int r1, input int r2);
      check({tag, ".r0"}, 64'(bus.regs_to_use[0]), 64'(r0));
      check({tag, ".r1"}, 64'(bus.regs_to_use[1]), 64'(r1));
      check({tag, ".r2"}, 64'(bus.regs_to_use[2]), 64'(r2));
   endtask

   task automatic idle_inputs();
      bus.updated_free_list = exp_fl;
      bus.num_dispatched    = 2'd0;
      bus.restore_valid     = 1'b0;
      bus.free_list_restore = 64'h0;
      bus.retire_valid      = 3'b000;
      bus.retire_reg        = '0;
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      exp_fl  = 64'hFFFFFFFF_00000000;
      idle_inputs();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Reset state
      check("rst.fl", bus.free_list_copy, 64'hFFFFFFFF_00000000);
      check_regs("rst", 32, 33, 34);
      check("rst.avail", 64'(bus.num_regs_available), 64'd3);
      check("rst.dbl", 64'(bus.double_free_err), 64'd0);
      check("rst.ovf", 64'(bus.alloc_overflow_err), 64'd0);
      check("rst.mask", bus.retire_free_mask, 64'h0);

      // Dispatch three: 32..34 allocated
      bus.updated_free_list = 64'hFFFFFFF8_00000000;
      bus.num_dispatched    = 2'd3;
      step();
      exp_fl = 64'hFFFFFFF8_00000000;
      check("disp.fl", bus.free_list_copy, exp_fl);
      check_regs("disp", 35, 36, 37);
      check("disp.ovf", 64'(bus.alloc_overflow_err), 64'd0);

      // Retire T_old = 5
      idle_inputs();
      bus.retire_valid  = 3'b001;
      bus.retire_reg[0] = 6'd5;
      #1 check("ret5.mask", bus.retire_free_mask, 64'h00000000_00000020);
      step();
      exp_fl = 64'hFFFFFFF8_00000020;
      check("ret5.fl", bus.free_list_copy, exp_fl);
      check_regs("ret5", 5, 35, 36);
      check("ret5.dbl", 64'(bus.double_free_err), 64'd0);

      // Restore (checkpoint missing 40, bit 0 set) with retire 7 and ignored dispatch
      idle_inputs();
      bus.restore_valid     = 1'b1;
      bus.free_list_restore = 64'hFFFFFEFF_00000001;
      bus.updated_free_list = 64'h0;
      bus.num_dispatched    = 2'd3;
      bus.retire_valid      = 3'b001;
      bus.retire_reg[0]     = 6'd7;
      step();
      exp_fl = 64'hFFFFFEFF_00000080;
      check("rest.fl", bus.free_list_copy, exp_fl);
      check_regs("rest", 7, 32, 33);
      check("rest.ovf", 64'(bus.alloc_overflow_err), 64'd0);

      // Drain to 62,63
      idle_inputs();
      bus.updated_free_list = 64'hC0000000_00000000;
      bus.num_dispatched    = 2'd3;
      step();
      exp_fl = 64'hC0000000_00000000;
      check("drain.fl", bus.free_list_copy, exp_fl);
      check("drain.avail", 64'(bus.num_regs_available), 64'd2);
      check_regs("drain", 62, 63, 0);

      // Restore while short on registers: dispatch count ignored, no overflow
      idle_inputs();
      bus.restore_valid     = 1'b1;
      bus.free_list_restore = 64'hC0000000_00000000;
      bus.updated_free_list = 64'h0;
      bus.num_dispatched    = 2'd3;
      step();
      check("rest2.ovf", 64'(bus.alloc_overflow_err), 64'd0);
      check("rest2.fl", bus.free_list_copy, exp_fl);

      // Overflow: dispatch 3 with only 2 available
      idle_inputs();
      bus.updated_free_list = 64'h0;
      bus.num_dispatched    = 2'd3;
      step();
      exp_fl = 64'h0;
      check("ovf.err", 64'(bus.alloc_overflow_err), 64'd1);
      check("ovf.fl", bus.free_list_copy, exp_fl);
      check("ovf.avail", 64'(bus.num_regs_available), 64'd0);
      check_regs("ovf", 0, 0, 0);

      // Overflow is sticky
      idle_inputs();
      step();
      check("ovf.sticky", 64'(bus.alloc_overflow_err), 64'd1);

      // Retire 50 and reg 0: reg 0 never becomes free
      idle_inputs();
      bus.retire_valid  = 3'b011;
      bus.retire_reg[0] = 6'd50;
      bus.retire_reg[1] = 6'd0;
      #1 check("r50.mask", bus.retire_free_mask, 64'h00040000_00000001);
      step();
      exp_fl = 64'h00040000_00000000;
      check("r50.fl", bus.free_list_copy, exp_fl);
      check("r50.dbl", 64'(bus.double_free_err), 64'd0);
      check_regs("r50", 50, 0, 0);
      check("r50.avail", 64'(bus.num_regs_available), 64'd1);

      // Retire 50 again: already free
      idle_inputs();
      bus.retire_valid  = 3'b001;
      bus.retire_reg[0] = 6'd50;
      step();
      check("dbl50.err", 64'(bus.double_free_err), 64'd1);
      check("dbl50.fl", bus.free_list_copy, exp_fl);

      // Async reset between edges during a restore
      idle_inputs();
      bus.restore_valid     = 1'b1;
      bus.free_list_restore = 64'h12345678_9ABCDEF0;
      bus.retire_valid      = 3'b001;
      bus.retire_reg[0]     = 6'd3;
      #3 reset = 1'b1;
      #1;
      check("arst.fl", bus.free_list_copy, 64'hFFFFFFFF_00000000);
      check_regs("arst", 32, 33, 34);
      check("arst.avail", 64'(bus.num_regs_available), 64'd3);
      check("arst.dbl", 64'(bus.double_free_err), 64'd0);
      check("arst.ovf", 64'(bus.alloc_overflow_err), 64'd0);
      exp_fl = 64'hFFFFFFFF_00000000;
      idle_inputs();
      step();
      reset = 1'b0;
      check("arst.hold", bus.free_list_copy, exp_fl);

      // Two slots retiring the same register
      idle_inputs();
      bus.retire_valid  = 3'b011;
      bus.retire_reg[0] = 6'd9;
      bus.retire_reg[1] = 6'd9;
      step();
      exp_fl = 64'hFFFFFFFF_00000200;
      check("dup.err", 64'(bus.double_free_err), 64'd1);
      check("dup.fl", bus.free_list_copy, exp_fl);
      check_regs("dup", 9, 32, 33);

      // Double-free error is sticky
      idle_inputs();
      step();
      check("dup.sticky", 64'(bus.double_free_err), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
